// File: rtl/dma_priority_arbiter_if.sv
// Channel request / bus-hold handshake bundle between the DMA arbiter and its surroundings.
interface dma_priority_arbiter_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] DREQ;
  logic [CHANNELS-1:0] maskReg;
  logic                rotatePriority;
  logic                controllerDisable;
  logic                HLDA;
  logic                serviceDone;
  logic                HRQ;
  logic [CHANNELS-1:0] DACK;
  logic [1:0]          activeChannel;
  logic                channelActive;
  logic [1:0]          lowestPriority;

  // master: pins, command register, CPU and timing-and-control side
  modport master (
    output DREQ, maskReg, rotatePriority, controllerDisable, HLDA, serviceDone,
    input  HRQ, DACK, activeChannel, channelActive, lowestPriority
  );

  // slave: the arbiter itself
  modport slave (
    input  DREQ, maskReg, rotatePriority, controllerDisable, HLDA, serviceDone,
    output HRQ, DACK, activeChannel, channelActive, lowestPriority
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// Fixed/rotating priority arbiter for the 4-channel DMA controller with HRQ/HLDA hold handshake.
module dma_priority_arbiter #(
  parameter int CHANNELS = 4
) (
  input logic                  CLK,
  input logic                  RESET,
  dma_priority_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t              state;
  logic [CHANNELS-1:0] eligible;
  logic [1:0]          winner;
  logic                found;
  logic [1:0]          idx;

  // Rotating mode starts the search just after the lowest-priority channel.
  always_comb begin
    eligible = bus.DREQ & ~bus.maskReg;
    winner   = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = bus.rotatePriority ? 2'(bus.lowestPriority + 2'(i) + 2'd1) : 2'(i);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state              <= S_IDLE;
      bus.HRQ            <= 1'b0;
      bus.DACK           <= '0;
      bus.channelActive  <= 1'b0;
      bus.activeChannel  <= 2'd0;
      bus.lowestPriority <= 2'd3;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.controllerDisable && found) begin
            bus.activeChannel <= winner;
            bus.HRQ           <= 1'b1;
            state             <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.HLDA) begin
            bus.DACK          <= CHANNELS'(1) << bus.activeChannel;
            bus.channelActive <= 1'b1;
            state             <= S_GRANT;
          end
        end
        S_GRANT: begin
          // serviceDone wins over a simultaneous HLDA drop so the rotation still happens.
          if (bus.serviceDone) begin
            bus.HRQ           <= 1'b0;
            bus.DACK          <= '0;
            bus.channelActive <= 1'b0;
            if (bus.rotatePriority)
              bus.lowestPriority <= bus.activeChannel;
            state <= S_RELEASE;
          end else if (!bus.HLDA) begin
            bus.HRQ           <= 1'b0;
            bus.DACK          <= '0;
            bus.channelActive <= 1'b0;
            state             <= S_IDLE;
          end
        end
        S_RELEASE: begin
          if (!bus.HLDA)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Randomized transaction-level bench for dma_priority_arbiter against a priority-order reference model.
module tb_dma_priority_arbiter;

  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] lp_model;

  always #5 CLK = ~CLK;

  dma_priority_arbiter_if #(.CHANNELS(4)) bus ();

  dma_priority_arbiter #(.CHANNELS(4)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Highest-priority eligible channel, or -1 when nothing is eligible.
  function automatic int pick(input logic [3:0] elig, input logic rot, input logic [1:0] lp);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = rot ? (int'(lp) + 1 + i) % 4 : i;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge CLK) begin
    if (!RESET && bus.DACK != 4'b0000) begin
      check("inv_onehot", 32'($onehot(bus.DACK)), 32'd1);
      check("inv_hrq", 32'(bus.HRQ), 32'd1);
    end
  end

  task automatic set_inputs(input logic [3:0] dreq, input logic [3:0] mask,
                            input logic rot, input logic dis);
    bus.DREQ              = dreq;
    bus.maskReg           = mask;
    bus.rotatePriority    = rot;
    bus.controllerDisable = dis;
    bus.HLDA              = 1'b0;
    bus.serviceDone       = 1'b0;
  endtask

  // ending: 0 = serviceDone, 1 = serviceDone with HLDA dropped together, 2 = abort
  task automatic run_txn(input logic [3:0] dreq, input logic [3:0] mask, input logic rot,
                         input logic dis, input int hd, input int hold, input int ending,
                         input int rel);
    int w;
    set_inputs(dreq, mask, rot, dis);
    w = dis ? -1 : pick(dreq & ~mask, rot, lp_model);
    tick();
    if (w < 0) begin
      check("noarb_hrq", 32'(bus.HRQ), 32'd0);
      tick();
      check("noarb_hrq2", 32'(bus.HRQ), 32'd0);
      check("noarb_dack", 32'(bus.DACK), 32'd0);
      return;
    end
    check("req_hrq", 32'(bus.HRQ), 32'd1);
    check("req_ch", 32'(bus.activeChannel), 32'(w));
    check("req_dack", 32'(bus.DACK), 32'd0);
    // Commitment: requests, mask and disable may change freely while waiting for HLDA.
    bus.DREQ              = 4'($urandom);
    bus.maskReg           = 4'($urandom);
    bus.controllerDisable = 1'($urandom);
    repeat (hd) begin
      bus.serviceDone = 1'($urandom);
      tick();
      check("wait_hrq", 32'(bus.HRQ), 32'd1);
      check("wait_dack", 32'(bus.DACK), 32'd0);
    end
    bus.serviceDone = 1'b0;
    bus.HLDA        = 1'b1;
    tick();
    check("grant_dack", 32'(bus.DACK), 32'(4'b0001 << w));
    check("grant_act", 32'(bus.channelActive), 32'd1);
    check("grant_ch", 32'(bus.activeChannel), 32'(w));
    repeat (hold) begin
      tick();
      check("hold_dack", 32'(bus.DACK), 32'(4'b0001 << w));
    end
    if (ending == 2) begin
      bus.HLDA = 1'b0;
      tick();
      check("abort_dack", 32'(bus.DACK), 32'd0);
      check("abort_hrq", 32'(bus.HRQ), 32'd0);
      check("abort_act", 32'(bus.channelActive), 32'd0);
      check("abort_lp", 32'(bus.lowestPriority), 32'(lp_model));
      return;
    end
    bus.serviceDone = 1'b1;
    if (ending == 1) bus.HLDA = 1'b0;
    tick();
    bus.serviceDone = 1'b0;
    if (rot) lp_model = 2'(w);
    check("done_dack", 32'(bus.DACK), 32'd0);
    check("done_hrq", 32'(bus.HRQ), 32'd0);
    check("done_act", 32'(bus.channelActive), 32'd0);
    check("done_lp", 32'(bus.lowestPriority), 32'(lp_model));
    if (bus.HLDA) begin
      repeat (rel) begin
        tick();
        check("rel_hrq", 32'(bus.HRQ), 32'd0);
        check("rel_dack", 32'(bus.DACK), 32'd0);
      end
      bus.HLDA = 1'b0;
    end
    tick();
    check("rel_exit_hrq", 32'(bus.HRQ), 32'd0);
  endtask

  initial begin
    RESET = 1'b1;
    set_inputs(4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    RESET = 1'b0;
    lp_model = 2'd3;
    check("rst_hrq", 32'(bus.HRQ), 32'd0);
    check("rst_dack", 32'(bus.DACK), 32'd0);
    check("rst_act", 32'(bus.channelActive), 32'd0);
    check("rst_ch", 32'(bus.activeChannel), 32'd0);
    check("rst_lp", 32'(bus.lowestPriority), 32'd3);

    // Reset in the middle of a grant on ch2.
    set_inputs(4'b0100, 4'b0000, 1'b0, 1'b0);
    tick();
    bus.HLDA = 1'b1;
    tick();
    check("midrst_pre_dack", 32'(bus.DACK), 32'h4);
    RESET = 1'b1;
    tick();
    check("midrst_hrq", 32'(bus.HRQ), 32'd0);
    check("midrst_dack", 32'(bus.DACK), 32'd0);
    check("midrst_lp", 32'(bus.lowestPriority), 32'd3);
    check("midrst_ch", 32'(bus.activeChannel), 32'd0);
    RESET = 1'b0;
    set_inputs(4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();

    // Fixed priority, HLDA one cycle after HRQ.
    run_txn(4'b1010, 4'b0000, 1'b0, 1'b0, 1, 2, 0, 0);

    // Rotating priority with all channels requesting.
    for (int i = 0; i < 4; i++) run_txn(4'b1111, 4'b0000, 1'b1, 1'b0, 0, 1, 0, 1);
    check("rot_lp_end", 32'(bus.lowestPriority), 32'd3);

    // Masking and disable.
    set_inputs(4'b0001, 4'b0001, 1'b0, 1'b0);
    tick();
    tick();
    check("mask_hrq", 32'(bus.HRQ), 32'd0);
    bus.maskReg           = 4'b0000;
    bus.controllerDisable = 1'b1;
    tick();
    tick();
    check("dis_hrq", 32'(bus.HRQ), 32'd0);
    bus.controllerDisable = 1'b0;
    tick();
    check("undis_hrq", 32'(bus.HRQ), 32'd1);
    check("undis_ch", 32'(bus.activeChannel), 32'd0);
    bus.HLDA = 1'b1;
    tick();
    check("undis_dack", 32'(bus.DACK), 32'h1);
    bus.serviceDone = 1'b1;
    bus.HLDA        = 1'b0;
    tick();
    bus.serviceDone = 1'b0;
    bus.DREQ        = 4'b0000;
    tick();

    // Abort on ch2 in rotating mode keeps lowestPriority.
    run_txn(4'b0100, 4'b0000, 1'b1, 1'b0, 0, 1, 2, 0);
    check("abort_lp_keep", 32'(bus.lowestPriority), 32'd3);

    // Commit: request dropped while waiting for HLDA.
    set_inputs(4'b0100, 4'b0000, 1'b0, 1'b0);
    tick();
    bus.DREQ = 4'b0000;
    tick();
    bus.HLDA = 1'b1;
    tick();
    check("commit_dack", 32'(bus.DACK), 32'h4);
    bus.serviceDone = 1'b1;
    tick();
    bus.serviceDone = 1'b0;
    check("commit_rel_dack", 32'(bus.DACK), 32'd0);
    bus.HLDA = 1'b0;
    tick();

    for (int t = 0; t < 120; t++) begin
      run_txn(4'($urandom),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
              1'($urandom),
              ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
